// File: rtl/block_config_pkg.sv
// block_config_pkg: shared types and constants for the configuration loader.
//   state_t   - loader FSM states
//   CRC_WIDTH - width of the frame check value
//   CRC_POLY  - CRC-8 generator polynomial (x^8 + x^2 + x + 1, implicit x^8)
package block_config_pkg;

   localparam int unsigned CRC_WIDTH = 8;
   localparam logic [CRC_WIDTH-1:0] CRC_POLY = 8'h07;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CRC,
      ST_COMMIT
   } state_t;

endpackage

// File: rtl/crc8_serial.sv
// crc8_serial: bit-serial CRC-8 (MSB-first, init 0, no reflection, no final XOR).
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset, clears the register
//   clear - synchronous clear at the start of a frame
//   en    - fold din into the CRC this cycle
//   din   - serial data bit
//   crc   - current CRC value
module crc8_serial
   import block_config_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 en,
   input  logic                 din,
   output logic [CRC_WIDTH-1:0] crc
);

   logic feedback;

   assign feedback = crc[CRC_WIDTH-1] ^ din;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         crc <= '0;
      end else if (en) begin
         crc <= {crc[CRC_WIDTH-2:0], 1'b0} ^ ({CRC_WIDTH{feedback}} & CRC_POLY);
      end
   end

endmodule

// File: rtl/block_config_loader.sv
// block_config_loader: serial-to-parallel loader for block-style config latches.
// Shifts TOTAL_BITS serial bits (first bit ends at the MSB) into config_out, then
// pulses comb_set for one cycle so every latch block captures its slice together.
// Optional frame CRC-8 check is compiled in by defining BLOCK_CONFIG_LOADER_CRC_EN.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   start       - begin a frame (sampled in IDLE only)
//   shift_in    - serial config bit, qualified by shift_valid
//   shift_valid - shift_in valid this cycle
//   shift_ready - loader accepts a bit this cycle (decoded from state)
//   config_out  - assembled frame, block i at [i*CFG_BITS +: CFG_BITS]
//   comb_set    - one-cycle capture strobe
//   busy        - FSM not in IDLE (decoded from state)
//   done        - sticky: last frame committed
//   crc_err     - sticky: last frame failed CRC (0 when CRC compiled out)
module block_config_loader
   import block_config_pkg::*;
#(
   parameter int unsigned CFG_BITS   = 16,
   parameter int unsigned NUM_BLOCKS = 4,
   parameter int unsigned TOTAL_BITS = CFG_BITS * NUM_BLOCKS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  shift_in,
   input  logic                  shift_valid,
   output logic                  shift_ready,
   output logic [TOTAL_BITS-1:0] config_out,
   output logic                  comb_set,
   output logic                  busy,
   output logic                  done,
   output logic                  crc_err
);

   localparam int unsigned CNT_W = $clog2(TOTAL_BITS + 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;

   assign busy        = (state != ST_IDLE);
   assign shift_ready = (state == ST_LOAD) || (state == ST_CRC);

`ifdef BLOCK_CONFIG_LOADER_CRC_EN
   logic [CRC_WIDTH-1:0] crc_calc;
   // Only 7 received bits are stored; the 8th is compared straight off shift_in.
   logic [CRC_WIDTH-2:0] rx_crc;
   logic [2:0]           crc_cnt;
   logic                 crc_err_q;

   assign crc_err = crc_err_q;

   crc8_serial u_crc (
      .clk   (clk),
      .rst   (rst),
      .clear (state == ST_IDLE && start),
      .en    (state == ST_LOAD && shift_valid),
      .din   (shift_in),
      .crc   (crc_calc)
   );
`else
   assign crc_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         config_out <= '0;
         cnt        <= '0;
         comb_set   <= 1'b0;
         done       <= 1'b0;
`ifdef BLOCK_CONFIG_LOADER_CRC_EN
         rx_crc     <= '0;
         crc_cnt    <= '0;
         crc_err_q  <= 1'b0;
`endif
      end else begin
         comb_set <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_LOAD;
                  cnt   <= '0;
                  done  <= 1'b0;
`ifdef BLOCK_CONFIG_LOADER_CRC_EN
                  rx_crc    <= '0;
                  crc_cnt   <= '0;
                  crc_err_q <= 1'b0;
`endif
               end
            end
            ST_LOAD: begin
               if (shift_valid) begin
                  config_out <= {config_out[TOTAL_BITS-2:0], shift_in};
                  cnt        <= cnt + CNT_W'(1);
                  if (cnt == CNT_W'(TOTAL_BITS - 1)) begin
`ifdef BLOCK_CONFIG_LOADER_CRC_EN
                     state <= ST_CRC;
`else
                     state    <= ST_COMMIT;
                     comb_set <= 1'b1;
`endif
                  end
               end
            end
`ifdef BLOCK_CONFIG_LOADER_CRC_EN
            ST_CRC: begin
               if (shift_valid) begin
                  rx_crc  <= {rx_crc[CRC_WIDTH-3:0], shift_in};
                  crc_cnt <= crc_cnt + 3'd1;
                  if (crc_cnt == 3'd7) begin
                     if (crc_calc == {rx_crc, shift_in}) begin
                        state    <= ST_COMMIT;
                        comb_set <= 1'b1;
                     end else begin
                        state     <= ST_IDLE;
                        crc_err_q <= 1'b1;
                     end
                  end
               end
            end
`endif
            ST_COMMIT: begin
               state <= ST_IDLE;
               done  <= 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/block_config_loader.md
# block_config_loader

Serial-to-parallel configuration loader that drives the block-style configuration latches of a tile. It accepts a serial configuration bitstream through a valid/ready handshake and assembles `NUM_BLOCKS` × `CFG_BITS` bits into a parallel frame. Once the frame is complete, it issues a single-cycle `comb_set` pulse so that every attached latch block captures its slice at the same time. It sits between the chip-level configuration shifter and the per-SLICEL latch blocks.

## Interface
Parameters:
- `CFG_BITS`, default 16: width of one latch block's `config_in`.
- `NUM_BLOCKS`, default 4: number of latch blocks fed from this loader.
- `TOTAL_BITS`, default `CFG_BITS*NUM_BLOCKS`: frame length. Derived; do not override.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `start`, input, 1: begins a frame. Sampled only in IDLE.
- `shift_in`, input, 1: serial configuration bit.
- `shift_valid`, input, 1: `shift_in` is valid this cycle.
- `shift_ready`, output, 1: loader accepts a bit this cycle.
- `config_out`, output, `TOTAL_BITS`: assembled frame. Block i's `config_in` is `config_out[i*CFG_BITS +: CFG_BITS]`.
- `comb_set`, output, 1: one-cycle capture strobe to all latch blocks.
- `busy`, output, 1: high whenever the FSM is not in IDLE.
- `done`, output, 1: sticky flag meaning the last frame was committed. Cleared when the next frame is accepted by `start`.
- `crc_err`, output, 1: sticky flag meaning the last frame failed its CRC check. Cleared when the next frame is accepted by `start`. Tied to 0 when CRC is compiled out.

## Operation
- **States:** IDLE, LOAD, CRC (CRC builds only), COMMIT.
- **IDLE:** `shift_ready`=0.
  - `start`=1 → LOAD. On the same edge the bit counter and CRC register clear, and `done` and `crc_err` clear.
  - `config_out` is not cleared on start. It keeps the old frame until new bits shift in.
- **LOAD:** `shift_ready`=1.
  - A bit transfers when `shift_valid`&&`shift_ready`.
  - Each transfer does `config_out <= {config_out[TOTAL_BITS-2:0], shift_in}` and increments the counter.
  - The first bit received ends up at `config_out[TOTAL_BITS-1]`, and the last bit at `[0]`.
  - Cycles with `shift_valid`=0 are stalls; no state changes.
  - On the transfer that brings the counter to `TOTAL_BITS`: go to CRC if enabled, otherwise to COMMIT.
- **CRC:** `shift_ready`=1.
  - Accepts exactly 8 further bits, MSB first, into the received-CRC register. `config_out` does not shift.
  - After the 8th transfer:
    - If computed == received → COMMIT.
    - Otherwise → IDLE with `crc_err`=1, and no `comb_set`.
- **COMMIT:** `shift_ready`=0, `comb_set`=1 for exactly one cycle, then → IDLE with `done`=1.
- **Counter:** width `$clog2(TOTAL_BITS+1)`. It never wraps, because the FSM leaves LOAD at `TOTAL_BITS`.
- **`start` outside IDLE:** ignored.
- **`shift_valid` outside LOAD/CRC:** ignored, and the bit is dropped.
- **Reset (any state, including mid-frame):**
  - State returns to IDLE.
  - `config_out`=0, counter=0, CRC=0.
  - `comb_set`=0, `shift_ready`=0, `busy`=0, `done`=0, `crc_err`=0.
  - The downstream latches keep their previous contents because no strobe is issued.

## Timing
- All outputs are registered, except `shift_ready` and `busy`, which decode directly from the state register.
- `start` sampled at edge k → `shift_ready`=1 in cycle k+1.
- Final frame bit (no CRC) or final CRC bit accepted at edge n → `comb_set`=1 during cycle n+1 → `done`=1 from cycle n+2.
- A CRC mismatch detected at edge n → `crc_err`=1 from cycle n+1.
- `config_out` is stable from the final frame-bit transfer until the next LOAD transfer. It is therefore valid throughout the `comb_set` cycle.
- Minimum frame time with no stalls: `TOTAL_BITS`+2 cycles (+8 with CRC), counted from `start`.

## Configuration
- **`BLOCK_CONFIG_LOADER_CRC_EN` defined:**
  - CRC state present.
  - CRC-8 with polynomial 0x07, init 0x00, no reflection, no final XOR.
  - Computed serially over the frame bits in arrival order.
  - A frame commits only on a CRC match.
- **Not defined:**
  - CRC state, CRC register and comparator are absent.
  - LOAD goes directly to COMMIT.
  - `crc_err` is tied to 0.

## Structure
- **Package `block_config_pkg`:** state enum (`ST_IDLE`, `ST_LOAD`, `ST_CRC`, `ST_COMMIT`), `CRC_WIDTH`=8, `CRC_POLY`=8'h07.
- **Sub-module `crc8_serial`:** one-bit-per-cycle LFSR with inputs `clk`, `rst`, `clear`, `en`, `din` and an 8-bit output `crc`. Instantiated only under the macro.

## Test plan
Run with `CFG_BITS`=16 and `NUM_BLOCKS`=4, so `TOTAL_BITS`=64.
1. **Stream without stalls (CRC off):** shift 64'hDEAD_BEEF_0123_4567 MSB first with no stalls → `config_out`=64'hDEAD_BEEF_0123_4567, one `comb_set` exactly 1 cycle after the 64th transfer, `done`=1 the following cycle.
2. **Stalls:** same frame with `shift_valid` toggled randomly (~50%) → identical `config_out`; `comb_set` asserted exactly once; no bits lost or duplicated.
3. **Reset mid-load:** assert `rst` after 30 bits → next cycle `config_out`=0, `busy`=0, `comb_set` never asserted. A fresh 64-bit frame after reset commits correctly.
4. **Ignored inputs:** `start` pulsed during LOAD and `shift_valid`=1 in IDLE → no state change, counter unaffected, `shift_ready` stays 0 in IDLE.
5. **CRC on, good CRC:** frame 64'h0 followed by CRC 8'h00 → `comb_set` pulses and `crc_err`=0. Frame 64'h1 followed by its correct CRC-8 (0x07 polynomial) also commits.
6. **CRC on, bad CRC:** frame 64'hDEAD_BEEF_0123_4567 followed by its correct CRC XOR 8'h01 → no `comb_set`, `crc_err`=1, `done`=0. The next `start` clears `crc_err`.
